// File: rtl/multiplier_controller_taint_track_1bit_pkg.sv
// Shared types for the shift-add multiplier controller: state encoding and strobe decode.
package mult_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic mdld;
    logic mrld;
    logic rsclear;
    logic rsload;
    logic rsshr;
    logic done;
  } strobe_t;

  // One strobe group per state; rsload and rsshr live in different states.
  function automatic strobe_t decode_strobes(input state_e s);
    strobe_t st;
    st = '0;
    case (s)
      S_LOAD: begin
        st.mdld    = 1'b1;
        st.mrld    = 1'b1;
        st.rsclear = 1'b1;
      end
      S_ADD:   st.rsload = 1'b1;
      S_SHIFT: st.rsshr  = 1'b1;
      S_DONE:  st.done   = 1'b1;
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/multiplier_controller_taint_track_1bit.sv
// Shift-add multiplier control FSM with a single taint bit on every control output.
// Latency: done 1+2*WIDTH+popcount(multiplier) edges after start is accepted; no backpressure, start ignored while busy.
// MULT_CTRL_TAINT_STICKY_EN: taint accumulates across operations until reset instead of per operation.
module multiplier_controller_taint_track_1bit
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic             multiplierReg_t,
  output logic             mdld,
  output logic             mrld,
  output logic             rsclear,
  output logic             rsload,
  output logic             rsshr,
  output logic             mdld_t,
  output logic             mrld_t,
  output logic             rsclear_t,
  output logic             rsload_t,
  output logic             rsshr_t,
  output logic             busy,
  output logic             done,
  output logic             done_t
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             taint_q, taint_d;
  logic             bit_sel;
  logic             idx_ok;
  strobe_t          stb;
  logic             taint_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      taint_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      taint_q <= taint_d;
    end
  end

  // Select multiplierReg[count] without an over-wide index.
  always_comb begin
    bit_sel = 1'b0;
    idx_ok  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (count_q == CNT_W'(i)) begin
        bit_sel = multiplierReg[i];
        idx_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    taint_d = taint_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
`ifdef MULT_CTRL_TAINT_STICKY_EN
          taint_d = taint_q | start_t;
`else
          taint_d = start_t;
`endif
        end
      end
      S_LOAD: state_d = S_CHECK;
      S_CHECK: begin
        // Branch timing depends on the multiplier value, so its taint enters here.
        taint_d = taint_q | multiplierReg_t;
        if (!idx_ok)      state_d = S_IDLE;
        else if (bit_sel) state_d = S_ADD;
        else              state_d = S_SHIFT;
      end
      S_ADD: state_d = S_SHIFT;
      S_SHIFT: begin
        count_d = count_q + CNT_W'(1);
        state_d = (count_q == CNT_W'(WIDTH - 1)) ? S_DONE : S_CHECK;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign stb       = decode_strobes(state_q);
  assign busy      = (state_q != S_IDLE);
  assign taint_out = busy & taint_q;

  assign mdld      = stb.mdld;
  assign mrld      = stb.mrld;
  assign rsclear   = stb.rsclear;
  assign rsload    = stb.rsload;
  assign rsshr     = stb.rsshr;
  assign done      = stb.done;

  assign mdld_t    = taint_out;
  assign mrld_t    = taint_out;
  assign rsclear_t = taint_out;
  assign rsload_t  = taint_out;
  assign rsshr_t   = taint_out;
  assign done_t    = taint_out;

endmodule

// File: tb/tb_multiplier_controller_taint_track_1bit.sv
// Bench for the multiplier controller: drives it with a behavioural shift-add datapath and checks products, latency and taint.
module tb_multiplier_controller_taint_track_1bit;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n, start, start_t, mr_t;
  logic [W-1:0] op_a, op_b, md_q, mr_q;
  logic [2*W:0] rs_q;
  logic mdld, mrld, rsclear, rsload, rsshr, busy, done;
  logic mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t, done_t;

  int n_vec = 0;
  int n_bad = 0;
  logic model_taint = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         st;
    logic         mt;
    int           prod;
    int           lat;
    logic         taint;
  } vec_t;
  vec_t tbl[5];

  multiplier_controller_taint_track_1bit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_t(start_t),
    .multiplierReg(mr_q), .multiplierReg_t(mr_t),
    .mdld(mdld), .mrld(mrld), .rsclear(rsclear), .rsload(rsload), .rsshr(rsshr),
    .mdld_t(mdld_t), .mrld_t(mrld_t), .rsclear_t(rsclear_t), .rsload_t(rsload_t), .rsshr_t(rsshr_t),
    .busy(busy), .done(done), .done_t(done_t)
  );

  always #5 clk = ~clk;

  // Datapath: multiplicand added into the upper half, whole register shifted right; rsshr wins over rsload.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_q <= '0;
      mr_q <= '0;
      rs_q <= '0;
    end else begin
      if (mdld) md_q <= op_a;
      if (mrld) mr_q <= op_b;
      if (rsclear)     rs_q <= '0;
      else if (rsshr)  rs_q <= rs_q >> 1;
      else if (rsload) rs_q <= rs_q + {1'b0, md_q, {W{1'b0}}};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic base_taint(input logic st);
`ifdef MULT_CTRL_TAINT_STICKY_EN
    return model_taint | st;
`else
    return st;
`endif
  endfunction

  function automatic logic [10:0] all_outs();
    return {mdld, mrld, rsclear, rsload, rsshr, done,
            mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("no_load_and_shr", {31'd0, rsload & rsshr}, 32'd0);
      chk("taint_uniform", {26'd0, mdld_t, mrld_t, rsclear_t, rsload_t, rsshr_t, done_t},
          {26'd0, {6{done_t}}});
      if (busy === 1'b0) chk("idle_outputs_zero", {21'd0, all_outs()}, 32'd0);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic st, input logic mt,
                        input bit hold, input int exp_prod, input int exp_lat, input logic exp_taint,
                        input string tag);
    bit   got, done_seen;
    int   k, lat, nload, nshr, nmd;
    logic base, exp_t;
    op_a = a; op_b = b; start_t = st; mr_t = mt; start = 1'b1;
    got = 0; k = 0;
    while (!got && k < 50) begin
      @(posedge clk); #1; k++;
      if (busy === 1'b1) got = 1;
    end
    chk({tag, "_accepted"}, {31'd0, got}, 32'd1);
    if (!hold) start = 1'b0;
    base = base_taint(st);
    nload = 0; nshr = 0; nmd = 0; lat = -1; done_seen = 0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      exp_t = (c >= 2) ? (base | mt) : base;
      chk({tag, "_taint_cycle"}, {31'd0, mdld_t}, {31'd0, exp_t});
      nload += int'(rsload); nshr += int'(rsshr); nmd += int'(mdld);
      if (done === 1'b1) begin done_seen = 1; lat = c; end
    end
    chk({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rsload_count"}, nload, $countones(b));
    chk({tag, "_rsshr_count"}, nshr, W);
    chk({tag, "_mdld_count"}, nmd, 1);
    chk({tag, "_product"}, {24'd0, rs_q[2*W-1:0]}, exp_prod);
    chk({tag, "_done_t"}, {31'd0, done_t}, {31'd0, exp_taint});
    model_taint = base | mt;
    if (!hold) begin
      @(posedge clk); #1;
      chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic rst_s, rmt;
    int   nshr;
    bit   hit;

    tbl[0] = '{a: 4'd5,  b: 4'd11, st: 1'b0, mt: 1'b0, prod: 55,  lat: 12, taint: 1'b0};
    tbl[1] = '{a: 4'd7,  b: 4'd0,  st: 1'b0, mt: 1'b0, prod: 0,   lat: 9,  taint: 1'b0};
    tbl[2] = '{a: 4'd15, b: 4'd15, st: 1'b0, mt: 1'b0, prod: 225, lat: 13, taint: 1'b0};
    tbl[3] = '{a: 4'd9,  b: 4'd6,  st: 1'b0, mt: 1'b1, prod: 54,  lat: 11, taint: 1'b1};
`ifdef MULT_CTRL_TAINT_STICKY_EN
    tbl[4] = '{a: 4'd3,  b: 4'd5,  st: 1'b0, mt: 1'b0, prod: 15,  lat: 11, taint: 1'b1};
`else
    tbl[4] = '{a: 4'd3,  b: 4'd5,  st: 1'b0, mt: 1'b0, prod: 15,  lat: 11, taint: 1'b0};
`endif

    rst_n = 1'b0; start = 1'b1; start_t = 1'b1; mr_t = 1'b1; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {20'd0, busy, all_outs()}, 32'd0);
    start = 1'b0; start_t = 1'b0; mr_t = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {20'd0, busy, all_outs()}, 32'd0);

    for (int i = 0; i < 5; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].st, tbl[i].mt, 1'b0,
             tbl[i].prod, tbl[i].lat, tbl[i].taint, $sformatf("tbl%0d", i));

    // Reset during the second SHIFT.
    op_a = 4'd3; op_b = 4'd15; start_t = 1'b1; mr_t = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nshr = 0; hit = 0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(posedge clk); #1;
      if (rsshr === 1'b1) nshr++;
      if (nshr == 2) hit = 1;
    end
    chk("reached_second_shift", {31'd0, hit}, 32'd1);
    rst_n = 1'b0; #1;
    chk("midop_reset_outputs", {20'd0, busy, all_outs()}, 32'd0);
    model_taint = 1'b0; start_t = 1'b0; mr_t = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_op(4'd3, 4'd6, 1'b0, 1'b0, 1'b0, 18, 11, 1'b0, "post_reset");

    // Start held high through two back-to-back operations.
    run_op(4'd2, 4'd3, 1'b0, 1'b0, 1'b1, 6, 11, base_taint(1'b0), "hold0");
    run_op(4'd1, 4'd1, 1'b0, 1'b0, 1'b1, 1, 10, base_taint(1'b0), "hold1");
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_released_idle", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      rst_s = 1'($urandom_range(0, 1));
      rmt = ($urandom_range(0, 3) == 0);
      run_op(ra, rb, rst_s, rmt, 1'b0, int'(ra) * int'(rb), 1 + 2 * W + $countones(rb),
             base_taint(rst_s) | rmt, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
